rx_pkt_sched: RTL and testbench
===============================

RX_PKT_SCHED -- requirements
Module: rx_pkt_sched

Interface
REQ-001 SHALL have parameter PKT_WORDS, default 256, 16-bit words read per packet (range 2..511).
REQ-002 SHALL have parameter GAP_CYCLES, default 2, idle cycles with RD low between packets (range 1..15).
REQ-003 SHALL have parameter TMO_CYCLES, default 4096, stall limit used only when RX_PKT_TMO_EN is defined.
REQ-004 SHALL have port rd_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port packet_rdy, input, 1 bit: FIFO holds at least one full packet; asynchronous to rd_clk.
REQ-007 SHALL have port usb_rdy, input, 1 bit: FX2 endpoint can accept a word this cycle.
REQ-008 SHALL have port overflow, input, 1 bit: FIFO overrun flag, synchronous to rd_clk.
REQ-009 SHALL have port clr_req, input, 1 bit: host request to clear status.
REQ-010 SHALL have port RD, output, 1 bit: FIFO read strobe, one word per high cycle.
REQ-011 SHALL have port clear_status, output, 1 bit: one-cycle clear pulse to the FIFO.
REQ-012 SHALL have port pkt_done, output, 1 bit: one-cycle pulse after the last word of a packet.
REQ-013 SHALL have port pkt_count, output, 16 bits: count of completed packets.
REQ-014 SHALL have port ovf_sticky, output, 1 bit: latched overflow.
REQ-015 SHALL have port tmo_flag, output, 1 bit: sticky timeout flag; constant 0 when RX_PKT_TMO_EN is undefined.
REQ-016 SHALL have port state, output, 2 bits: FSM state for the debug bus.

Function
REQ-017 SHALL synchronize packet_rdy through two flops; only the synchronized value is used, giving 2 cycles of latency.
REQ-018 SHALL implement the FSM states IDLE=0, ARM=1, READ=2, GAP=3.
REQ-019 IDLE SHALL go to ARM when synced packet_rdy=1.
REQ-020 ARM SHALL go to READ on the cycle usb_req... corrected: on the cycle usb_rdy=1, and SHALL load word_cnt=0.
REQ-021 In READ, RD SHALL equal usb_rdy combinationally.
REQ-022 In READ, word_cnt SHALL increment each cycle RD=1 and hold while usb_rdy=0 (stall, no word lost).
REQ-023 When RD=1 and word_cnt=PKT_WORDS-1, the FSM SHALL go to GAP and pkt_done SHALL pulse on the next cycle; exactly PKT_WORDS RD cycles occur per packet.
REQ-024 GAP SHALL hold RD=0 for exactly GAP_CYCLES cycles, then go to IDLE; packet_rdy is not sampled during GAP.
REQ-025 RD SHALL be 0 in every state except READ.
REQ-026 pkt_count SHALL increment with pkt_done and wrap from 0xFFFF to 0.
REQ-027 ovf_sticky SHALL set when overflow=1 and clear only via clear_status; if set and clear occur together, set wins.
REQ-028 clr_req=1 SHALL produce a clear_status pulse the next cycle; a held clr_req SHALL produce one pulse per rising edge of clr_req.
REQ-029 clear_status SHALL also clear tmo_flag and SHALL NOT affect pkt_count or the FSM.
REQ-030 A deassertion of packet_rdy during READ SHALL be ignored; the packet completes.

Reset
REQ-031 While reset=0 at a clock edge: state=IDLE, RD=0, clear_status=0, pkt_done=0, pkt_count=0, ovf_sticky=0, tmo_flag=0, word_cnt=0, gap counter=0, synchronizer flops=0.
REQ-032 Reset asserted mid-READ SHALL drop RD on the next edge with no pkt_done.

Configuration
REQ-033 With macro RX_PKT_TMO_EN defined, a stall counter SHALL count consecutive cycles in ARM, or in READ with usb_rdy=0.
REQ-034 With RX_PKT_TMO_EN defined, reaching TMO_CYCLES SHALL force GAP, set tmo_flag, and produce no pkt_done.
REQ-035 With RX_PKT_TMO_EN undefined, the stall counter SHALL be absent, tmo_flag SHALL be tied to 0, and stalls SHALL be indefinite.

Verification
REQ-036 Reset=0 for 3 cycles, then 1 -> all outputs 0, state=0.
REQ-037 packet_rdy=1, usb_rdy=1 steady -> RD high exactly 256 consecutive cycles, pkt_done one cycle later, pkt_count=1, then RD low for 2 cycles.
REQ-038 usb_rdy toggles 0/1 during READ -> total RD-high cycles=256, pkt_done once.
REQ-039 overflow pulse 1 cycle, then clr_req held 5 cycles -> ovf_sticky=1 until one clear_status pulse, then 0.
REQ-040 RX_PKT_TMO_EN with TMO_CYCLES=16, usb_rdy=0 in ARM -> state=GAP after 16 cycles, tmo_flag=1, pkt_count unchanged.
REQ-041 Reset=0 at word 100 of READ -> RD=0 next cycle, pkt_count=0, state=IDLE.

Source files
------------

// File: rtl/rx_pkt_sched.sv
// Receive-side packet scheduler: drains PKT_WORDS-word packets from the FIFO into the FX2 endpoint.
// Optional stall timeout is compiled in when macro RX_PKT_TMO_EN is defined.
module rx_pkt_sched #(
    parameter int PKT_WORDS  = 256,
    parameter int GAP_CYCLES = 2,
    parameter int TMO_CYCLES = 4096
) (
    input  logic        rd_clk,
    input  logic        reset,
    input  logic        packet_rdy,
    input  logic        usb_rdy,
    input  logic        overflow,
    input  logic        clr_req,
    output logic        RD,
    output logic        clear_status,
    output logic        pkt_done,
    output logic [15:0] pkt_count,
    output logic        ovf_sticky,
    output logic        tmo_flag,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        READ = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam logic [8:0] LAST_WORD = 9'(PKT_WORDS - 1);
    localparam logic [3:0] LAST_GAP  = 4'(GAP_CYCLES - 1);

    // Elaborates only when a parameter is outside its supported range.
    if (PKT_WORDS < 2 || PKT_WORDS > 511 || GAP_CYCLES < 1 || GAP_CYCLES > 15 ||
        TMO_CYCLES < 1) begin : g_bad_params
    end

    state_t      state_q, state_d;
    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic [8:0]  word_cnt_q, word_cnt_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic        pkt_done_q, pkt_done_d;
    logic [15:0] pkt_count_q, pkt_count_d;
    logic        ovf_q, ovf_d;
    logic        clr_prev_q, clr_prev_d;
    logic        clear_q, clear_d;
    logic        rd_now;
    logic        timeout;

    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        pkt_done_d  = 1'b0;
        rd_now      = 1'b0;
        sync1_d     = packet_rdy;
        sync2_d     = sync1_q;
        clr_prev_d  = clr_req;
        clear_d     = clr_req & ~clr_prev_q;

        case (state_q)
            IDLE: begin
                if (sync2_q) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                if (usb_rdy) begin
                    state_d    = READ;
                    word_cnt_d = '0;
                end
            end
            READ: begin
                rd_now = usb_rdy;
                if (usb_rdy) begin
                    if (word_cnt_q == LAST_WORD) begin
                        state_d    = GAP;
                        gap_cnt_d  = '0;
                        pkt_done_d = 1'b1;
                    end else begin
                        word_cnt_d = word_cnt_q + 9'd1;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == LAST_GAP) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A stall timeout abandons the packet: straight to GAP, no completion pulse.
        if (timeout) begin
            state_d    = GAP;
            gap_cnt_d  = '0;
            pkt_done_d = 1'b0;
        end

        pkt_count_d = pkt_count_q + {15'd0, pkt_done_d};
        ovf_d       = overflow | (ovf_q & ~clear_q);
    end

    always_ff @(posedge rd_clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            word_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            pkt_done_q  <= 1'b0;
            pkt_count_q <= '0;
            ovf_q       <= 1'b0;
            clr_prev_q  <= 1'b0;
            clear_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            word_cnt_q  <= word_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            pkt_done_q  <= pkt_done_d;
            pkt_count_q <= pkt_count_d;
            ovf_q       <= ovf_d;
            clr_prev_q  <= clr_prev_d;
            clear_q     <= clear_d;
        end
    end

`ifdef RX_PKT_TMO_EN
    localparam int STALL_W = $clog2(TMO_CYCLES + 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TMO_CYCLES - 1);

    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
    logic               tmo_q, tmo_d;
    logic               stalled;

    // Waiting in ARM counts as a stall too: the endpoint never became ready.
    always_comb begin
        stalled     = ((state_q == ARM) || (state_q == READ)) && !usb_rdy;
        timeout     = stalled && (stall_cnt_q == STALL_LAST);
        stall_cnt_d = (stalled && !timeout) ? stall_cnt_q + 1'b1 : '0;
        tmo_d       = timeout | (tmo_q & ~clear_q);
    end

    always_ff @(posedge rd_clk) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            tmo_q       <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            tmo_q       <= tmo_d;
        end
    end

    assign tmo_flag = tmo_q;
`else
    assign timeout  = 1'b0;
    assign tmo_flag = 1'b0;
`endif

    assign RD           = rd_now;
    assign clear_status = clear_q;
    assign pkt_done     = pkt_done_q;
    assign pkt_count    = pkt_count_q;
    assign ovf_sticky   = ovf_q;
    assign state        = state_q;

endmodule

// File: tb/tb_rx_pkt_sched.sv
// Self-checking bench for rx_pkt_sched: packet-level reference model plus directed literal checks.
// Timeout scenario runs only when RX_PKT_TMO_EN is defined (TMO_CYCLES=16 here).
module tb_rx_pkt_sched;

    localparam int PKT_WORDS  = 256;
    localparam int GAP_CYCLES = 2;
    localparam int TMO_CYCLES = 16;

    logic        rd_clk     = 1'b0;
    logic        reset      = 1'b0;
    logic        packet_rdy = 1'b0;
    logic        usb_rdy    = 1'b0;
    logic        overflow   = 1'b0;
    logic        clr_req    = 1'b0;
    logic        RD;
    logic        clear_status;
    logic        pkt_done;
    logic [15:0] pkt_count;
    logic        ovf_sticky;
    logic        tmo_flag;
    logic [1:0]  state;

    int checks = 0;
    int passes = 0;

    rx_pkt_sched #(
        .PKT_WORDS (PKT_WORDS),
        .GAP_CYCLES(GAP_CYCLES),
        .TMO_CYCLES(TMO_CYCLES)
    ) dut (
        .rd_clk      (rd_clk),
        .reset       (reset),
        .packet_rdy  (packet_rdy),
        .usb_rdy     (usb_rdy),
        .overflow    (overflow),
        .clr_req     (clr_req),
        .RD          (RD),
        .clear_status(clear_status),
        .pkt_done    (pkt_done),
        .pkt_count   (pkt_count),
        .ovf_sticky  (ovf_sticky),
        .tmo_flag    (tmo_flag),
        .state       (state)
    );

    always #5 rd_clk = ~rd_clk;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // One call = one clock cycle; inputs change just after the rising edge.
    task automatic apply_stimulus(input logic rst, input logic prdy, input logic urdy,
                                  input logic ovf, input logic clr);
        @(posedge rd_clk);
        #1;
        reset      = rst;
        packet_rdy = prdy;
        usb_rdy    = urdy;
        overflow   = ovf;
        clr_req    = clr;
    endtask

    // Reference model: phase number, words moved so far, gap cycles remaining.
    int m_state = 0;
    int m_words = 0;
    int m_gap   = 0;
    int m_cnt   = 0;
    bit m_pr1 = 1'b0, m_pr2 = 1'b0;
    bit m_done = 1'b0, m_clr = 1'b0, m_clr_prev = 1'b0;
    bit m_ovf = 1'b0, m_tmo = 1'b0;
    bit model_valid = 1'b0;
`ifdef RX_PKT_TMO_EN
    int m_stall = 0;
`endif

    always @(posedge rd_clk) begin
        int nxt;
        bit done_n;
        bit tmo_hit;
        if (!reset) begin
            m_state = 0; m_words = 0; m_gap = 0; m_cnt = 0;
            m_pr1 = 0; m_pr2 = 0; m_done = 0; m_clr = 0; m_clr_prev = 0;
            m_ovf = 0; m_tmo = 0;
`ifdef RX_PKT_TMO_EN
            m_stall = 0;
`endif
        end else begin
            nxt = m_state;
            done_n = 1'b0;
            tmo_hit = 1'b0;
            case (m_state)
                0: if (m_pr2) nxt = 1;
                1: if (usb_rdy) begin nxt = 2; m_words = 0; end
                2: if (usb_rdy) begin
                       m_words++;
                       if (m_words == PKT_WORDS) begin
                           nxt = 3; m_gap = GAP_CYCLES; done_n = 1'b1;
                       end
                   end
                default: begin m_gap--; if (m_gap == 0) nxt = 0; end
            endcase
`ifdef RX_PKT_TMO_EN
            if ((m_state == 1 || m_state == 2) && !usb_rdy) m_stall++;
            else m_stall = 0;
            if (m_stall == TMO_CYCLES) begin
                nxt = 3; m_gap = GAP_CYCLES; m_stall = 0; tmo_hit = 1'b1;
            end
`endif
            m_state    = nxt;
            m_done     = done_n;
            m_cnt      = (m_cnt + int'(done_n)) % 65536;
            m_ovf      = overflow || (m_ovf && !m_clr);
            m_tmo      = tmo_hit || (m_tmo && !m_clr);
            m_clr      = clr_req && !m_clr_prev;
            m_clr_prev = clr_req;
            m_pr2      = m_pr1;
            m_pr1      = packet_rdy;
        end
    end

    always @(negedge rd_clk) begin
        if (model_valid) begin
            check_output("RD", int'(RD), int'(m_state == 2 && usb_rdy));
            check_output("pkt_done", int'(pkt_done), int'(m_done));
            check_output("pkt_count", int'(pkt_count), m_cnt);
            check_output("clear_status", int'(clear_status), int'(m_clr));
            check_output("ovf_sticky", int'(ovf_sticky), int'(m_ovf));
            check_output("tmo_flag", int'(tmo_flag), int'(m_tmo));
            check_output("state", int'(state), m_state);
        end
    end

    initial begin
        int rd_cycles, runs, low_cycles, gap_seen, done_pulses, clr_pulses, arm_cycles;
        bit done_seen, prev_rd, rd_back, ovf_at_pulse;

        $display("[TB] rx_pkt_sched bench starting");

        // Reset held low for three edges.
        apply_stimulus(0, 0, 0, 0, 0);
        model_valid = 1'b1;
        apply_stimulus(0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0);
        @(negedge rd_clk);
        check_output("reset_RD", int'(RD), 0);
        check_output("reset_clear_status", int'(clear_status), 0);
        check_output("reset_pkt_done", int'(pkt_done), 0);
        check_output("reset_pkt_count", int'(pkt_count), 0);
        check_output("reset_ovf_sticky", int'(ovf_sticky), 0);
        check_output("reset_tmo_flag", int'(tmo_flag), 0);
        check_output("reset_state", int'(state), 0);

        // Packet 1: steady ready on both sides.
        apply_stimulus(1, 1, 1, 0, 0);
        rd_cycles = 0; runs = 0; done_seen = 0; prev_rd = 0;
        for (int i = 0; i < 600 && !done_seen; i++) begin
            @(negedge rd_clk);
            if (RD && !prev_rd) runs++;
            if (RD) rd_cycles++;
            if (pkt_done) begin
                done_seen = 1'b1;
                check_output("done_follows_last_word", int'(prev_rd), 1);
                check_output("pkt1_count", int'(pkt_count), 1);
            end
            prev_rd = RD;
            if (!done_seen) apply_stimulus(1, 1, 1, 0, 0);
        end
        check_output("pkt1_done_seen", int'(done_seen), 1);
        check_output("pkt1_rd_cycles", rd_cycles, 256);
        check_output("pkt1_rd_runs", runs, 1);

        // Gap, then IDLE and ARM, before the next packet; packet_rdy now drops.
        low_cycles = 0; gap_seen = 0; rd_back = 0;
        for (int i = 0; i < 20 && !rd_back; i++) begin
            if (state == 2'd3) gap_seen++;
            if (RD) begin
                rd_back = 1'b1;
            end else begin
                low_cycles++;
                apply_stimulus(1, 0, 1, 0, 0);
                @(negedge rd_clk);
            end
        end
        check_output("gap_cycles", gap_seen, 2);
        check_output("rd_low_between_pkts", low_cycles, 4);
        check_output("pkt2_started", int'(rd_back), 1);

        // Packet 2: usb_rdy toggles plus one 10-cycle stall, packet_rdy low throughout.
        rd_cycles = 1; done_pulses = 0;
        for (int i = 0; i < 1500 && done_pulses == 0; i++) begin
            apply_stimulus(1, 0, (i >= 50 && i < 60) ? 1'b0 : (i % 2 == 1), 0, 0);
            @(negedge rd_clk);
            if (RD) rd_cycles++;
            if (pkt_done) done_pulses++;
        end
        check_output("pkt2_rd_cycles", rd_cycles, 256);
        check_output("pkt2_count", int'(pkt_count), 2);
        for (int i = 0; i < 12; i++) begin
            apply_stimulus(1, 0, 1, 0, 0);
            @(negedge rd_clk);
            if (RD) rd_cycles++;
            if (pkt_done) done_pulses++;
        end
        check_output("pkt2_done_pulses", done_pulses, 1);
        check_output("no_rd_when_not_ready", rd_cycles, 256);
        check_output("idle_after_pkt2", int'(state), 0);

        // Overflow pulse, then clr_req held for five cycles.
        apply_stimulus(1, 0, 0, 1, 0);
        apply_stimulus(1, 0, 0, 0, 0);
        @(negedge rd_clk);
        check_output("ovf_latched", int'(ovf_sticky), 1);
        clr_pulses = 0; ovf_at_pulse = 0;
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1, 0, 0, 0, (i < 5));
            @(negedge rd_clk);
            if (clear_status) begin
                clr_pulses++;
                ovf_at_pulse = ovf_sticky;
            end
        end
        check_output("held_clr_one_pulse", clr_pulses, 1);
        check_output("ovf_held_until_clear", int'(ovf_at_pulse), 1);
        check_output("ovf_cleared", int'(ovf_sticky), 0);

        // Overflow coinciding with the clear pulse: set wins.
        apply_stimulus(1, 0, 0, 0, 1);
        apply_stimulus(1, 0, 0, 1, 0);
        apply_stimulus(1, 0, 0, 0, 0);
        @(negedge rd_clk);
        check_output("ovf_set_beats_clear", int'(ovf_sticky), 1);
        apply_stimulus(1, 0, 0, 0, 1);
        apply_stimulus(1, 0, 0, 0, 0);
        apply_stimulus(1, 0, 0, 0, 0);
        @(negedge rd_clk);
        check_output("ovf_cleared_again", int'(ovf_sticky), 0);
        check_output("clear_keeps_count", int'(pkt_count), 2);

        // Reset asserted after 100 words of a packet.
        apply_stimulus(1, 1, 1, 0, 0);
        rd_cycles = 0;
        for (int i = 0; i < 300 && rd_cycles < 100; i++) begin
            @(negedge rd_clk);
            if (RD) rd_cycles++;
            if (rd_cycles < 100) apply_stimulus(1, 1, 1, 0, 0);
        end
        check_output("words_before_reset", rd_cycles, 100);
        apply_stimulus(0, 1, 1, 0, 0);
        apply_stimulus(0, 0, 1, 0, 0);
        @(negedge rd_clk);
        check_output("midread_reset_RD", int'(RD), 0);
        check_output("midread_reset_count", int'(pkt_count), 0);
        check_output("midread_reset_state", int'(state), 0);
        check_output("midread_reset_done", int'(pkt_done), 0);
        apply_stimulus(1, 0, 0, 0, 0);
        apply_stimulus(1, 0, 0, 0, 0);

`ifdef RX_PKT_TMO_EN
        // Endpoint never ready: ARM must give up after TMO_CYCLES.
        apply_stimulus(1, 1, 0, 0, 0);
        arm_cycles = 0;
        for (int i = 0; i < 60 && state != 2'd3; i++) begin
            @(negedge rd_clk);
            if (state == 2'd1) arm_cycles++;
            if (state != 2'd3) apply_stimulus(1, 1, 0, 0, 0);
        end
        check_output("tmo_arm_cycles", arm_cycles, 16);
        check_output("tmo_state_gap", int'(state), 3);
        check_output("tmo_flag_set", int'(tmo_flag), 1);
        check_output("tmo_count_unchanged", int'(pkt_count), 0);
        apply_stimulus(1, 0, 0, 0, 1);
        apply_stimulus(1, 0, 0, 0, 0);
        apply_stimulus(1, 0, 0, 0, 0);
        @(negedge rd_clk);
        check_output("tmo_flag_cleared", int'(tmo_flag), 0);
`endif

        apply_stimulus(1, 0, 0, 0, 0);
        @(negedge rd_clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
